// File: rtl/basys3_io_pkg.sv
// Shared constants and types for the Basys3 switch/button input controller.
package basys3_io_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned NUM_SW_DEFAULT          = 16;
  localparam int unsigned NUM_BTN                 = 5;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_R = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_L = 4;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } evt_state_e;

  // Debounce counter width; a single-cycle debounce still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/basys3_input_ctrl_if.sv
// Board-side inputs, debounced outputs and the button event handshake.
interface basys3_input_ctrl_if
  import basys3_io_pkg::*;
#(
  parameter int unsigned NUM_SW = NUM_SW_DEFAULT
) ();

  logic [NUM_SW-1:0]  sw_raw;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_SW-1:0]  sw_stable;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic               evt_valid;
  logic [NUM_BTN-1:0] evt_code;
  logic               evt_ready;
  logic               evt_overflow;
  logic               ovf_clr;

  modport master (
    output sw_raw, btn_raw, evt_ready, ovf_clr,
    input  sw_stable, btn_level, btn_press, evt_valid, evt_code, evt_overflow
  );

  modport slave (
    input  sw_raw, btn_raw, evt_ready, ovf_clr,
    output sw_stable, btn_level, btn_press, evt_valid, evt_code, evt_overflow
  );

endinterface

// File: rtl/debounce_channel.sv
// One-bit debouncer: 2-flop synchronizer, consecutive-difference counter, stable flop.
module debounce_channel
  import basys3_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      // Any sample matching the stable level restarts the count, so bounces never accumulate.
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/basys3_input_ctrl.sv
// Debounces all switches and buttons, then queues button presses as a single pending event.
module basys3_input_ctrl
  import basys3_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned NUM_SW          = NUM_SW_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  basys3_input_ctrl_if.slave bus
);

  logic [NUM_SW-1:0]  w_sw_stable;
  logic [NUM_BTN-1:0] w_btn_level;
  logic [NUM_BTN-1:0] w_press;
  logic               w_any_press;
  logic               w_transfer;
  logic               w_ovf_set;

  evt_state_e         r_state;
  logic [NUM_BTN-1:0] r_code;
  logic [NUM_BTN-1:0] r_level_dly;
  logic               r_ovf;

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (bus.sw_raw[gi]),
      .o_stable(w_sw_stable[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (bus.btn_raw[gi]),
      .o_stable(w_btn_level[gi])
    );
  end

  // Rising edge of the debounced level; both terms are flops so the pulse is glitch-free.
  assign w_press     = w_btn_level & ~r_level_dly;
  assign w_any_press = |w_press;
  assign w_transfer  = (r_state == StFull) && bus.evt_ready;
  assign w_ovf_set   = (r_state == StFull) && !bus.evt_ready && (|(w_press & r_code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StEmpty;
      r_code      <= '0;
      r_level_dly <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_level_dly <= w_btn_level;
      r_ovf       <= w_ovf_set | (r_ovf & ~bus.ovf_clr);
      unique case (r_state)
        StEmpty: begin
          if (w_any_press) begin
            r_code  <= w_press;
            r_state <= StFull;
          end
        end
        StFull: begin
          if (w_transfer) begin
            // A press on the transfer edge becomes the next event; otherwise this clears.
            r_code <= w_press;
            if (!w_any_press) begin
              r_state <= StEmpty;
            end
          end else begin
            r_code <= r_code | w_press;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign bus.sw_stable    = w_sw_stable;
  assign bus.btn_level    = w_btn_level;
  assign bus.btn_press    = w_press;
  assign bus.evt_valid    = (r_state == StFull);
  assign bus.evt_code     = r_code;
  assign bus.evt_overflow = r_ovf;

endmodule

// File: tb/tb_basys3_input_ctrl.sv
// Scoreboard bench: stimulus schedules expected values per clock edge, a monitor checks them.
module tb_basys3_input_ctrl;
  import basys3_io_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned NSW = 16;

  typedef enum int {SigSw, SigLevel, SigPress, SigValid, SigCode, SigOvf} sig_e;
  typedef struct {
    int          at;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  basys3_input_ctrl_if #(.NUM_SW(NSW)) bus ();

  basys3_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_SW         (NSW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SigSw:    return 32'(bus.sw_stable);
      SigLevel: return 32'(bus.btn_level);
      SigPress: return 32'(bus.btn_press);
      SigValid: return 32'(bus.evt_valid);
      SigCode:  return 32'(bus.evt_code);
      SigOvf:   return 32'(bus.evt_overflow);
      default:  return '0;
    endcase
  endfunction

  task automatic exp_at(input int at, input sig_e s, input logic [31:0] v, input string n);
    sb.push_back('{at: at, sig: s, val: v, name: n});
  endtask

  task automatic exp_all_zero(input int at, input string n);
    exp_at(at, SigSw, 0, {n, "_sw"});
    exp_at(at, SigLevel, 0, {n, "_level"});
    exp_at(at, SigPress, 0, {n, "_press"});
    exp_at(at, SigValid, 0, {n, "_valid"});
    exp_at(at, SigCode, 0, {n, "_code"});
    exp_at(at, SigOvf, 0, {n, "_ovf"});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: sample between edges, compare every expectation due at this edge count.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at <= edges) begin
          act = sample(sb[i].sig);
          checks++;
          if (sb[i].at < edges || act !== sb[i].val) begin
            errors++;
            $display("FAIL %s edge %0d: got 'h%0h expected 'h%0h", sb[i].name, sb[i].at, act,
                     sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int e;
    bus.sw_raw    = '0;
    bus.btn_raw   = '0;
    bus.evt_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    tick(2);
    exp_all_zero(edges, "reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Switch step appears exactly DEB+2 edges after sampling.
    e = edges;
    bus.sw_raw = 16'hA5A5;
    exp_at(e + 5, SigSw, 0, "sw_pre");
    exp_at(e + 6, SigSw, 32'hA5A5, "sw_step");
    exp_at(e + 10, SigSw, 32'hA5A5, "sw_hold");
    tick(11);
    checks++;
    if (bus.sw_stable !== 16'hA5A5) begin
      errors++;
      $display("FAIL sw_direct: got 'h%0h expected 'hA5A5", bus.sw_stable);
    end

    // Bouncing centre button, then steady high.
    bus.btn_raw[BTN_C] = 1'b1; tick(1);
    bus.btn_raw[BTN_C] = 1'b0; tick(1);
    bus.btn_raw[BTN_C] = 1'b1; tick(1);
    bus.btn_raw[BTN_C] = 1'b0; tick(1);
    e = edges;
    bus.btn_raw[BTN_C] = 1'b1;
    exp_at(e + 5, SigLevel, 0, "c_level_pre");
    exp_at(e + 5, SigPress, 0, "c_press_pre");
    exp_at(e + 6, SigPress, 32'h01, "c_press");
    exp_at(e + 6, SigLevel, 32'h01, "c_level");
    exp_at(e + 7, SigPress, 0, "c_press_end");
    exp_at(e + 7, SigValid, 1, "c_valid");
    exp_at(e + 7, SigCode, 32'h01, "c_code");
    tick(9);

    // Transfer, then ready held while empty.
    e = edges;
    bus.evt_ready = 1'b1;
    exp_at(e + 1, SigValid, 0, "xfer_empty");
    exp_at(e + 1, SigCode, 0, "xfer_code_clr");
    exp_at(e + 2, SigValid, 0, "ready_while_empty");
    tick(2);
    bus.evt_ready = 1'b0;

    e = edges;
    bus.btn_raw[BTN_C] = 1'b0;
    exp_at(e + 6, SigLevel, 0, "c_release");
    exp_at(e + 6, SigPress, 0, "no_release_pulse");
    exp_at(e + 7, SigValid, 0, "no_release_event");
    tick(8);

    // U, then L ORed in, then U again overflows.
    e = edges;
    bus.btn_raw[BTN_U] = 1'b1;
    exp_at(e + 6, SigPress, 32'h02, "u_press");
    exp_at(e + 7, SigValid, 1, "u_valid");
    exp_at(e + 7, SigCode, 32'h02, "u_code");
    tick(8);
    e = edges;
    bus.btn_raw[BTN_L] = 1'b1;
    exp_at(e + 7, SigCode, 32'h12, "l_or");
    exp_at(e + 7, SigOvf, 0, "l_no_ovf");
    tick(8);
    bus.btn_raw[BTN_U] = 1'b0;
    bus.btn_raw[BTN_L] = 1'b0;
    tick(8);
    e = edges;
    bus.btn_raw[BTN_U] = 1'b1;
    exp_at(e + 6, SigOvf, 0, "u_ovf_pre");
    exp_at(e + 7, SigOvf, 1, "u_again_ovf");
    exp_at(e + 7, SigCode, 32'h12, "u_again_code");
    exp_at(e + 7, SigValid, 1, "u_again_valid");
    tick(8);

    // Plain clear, then clear colliding with a new overflow.
    e = edges;
    bus.ovf_clr = 1'b1;
    exp_at(e + 1, SigOvf, 0, "ovf_clr");
    tick(1);
    bus.ovf_clr = 1'b0;
    bus.btn_raw[BTN_U] = 1'b0;
    tick(8);
    e = edges;
    bus.btn_raw[BTN_U] = 1'b1;
    tick(6);
    bus.ovf_clr = 1'b1;
    exp_at(e + 7, SigOvf, 1, "ovf_set_wins");
    tick(1);
    e = edges;
    exp_at(e + 1, SigOvf, 0, "ovf_clr2");
    tick(1);
    bus.ovf_clr = 1'b0;

    // Drain, then C pending and D pressed on the transfer edge.
    e = edges;
    bus.evt_ready = 1'b1;
    exp_at(e + 1, SigValid, 0, "xfer2");
    tick(1);
    bus.evt_ready = 1'b0;
    bus.btn_raw[BTN_U] = 1'b0;
    tick(8);
    e = edges;
    bus.btn_raw[BTN_C] = 1'b1;
    exp_at(e + 7, SigCode, 32'h01, "c_again");
    tick(8);
    e = edges;
    bus.btn_raw[BTN_D] = 1'b1;
    tick(6);
    bus.evt_ready = 1'b1;
    exp_at(e + 7, SigValid, 1, "xfer_press_valid");
    exp_at(e + 7, SigCode, 32'h08, "xfer_press_code");
    exp_at(e + 7, SigOvf, 0, "xfer_press_ovf");
    tick(1);
    bus.evt_ready = 1'b0;
    tick(2);

    // Asynchronous reset mid-debounce with an event pending.
    bus.sw_raw = 16'h0F0F;
    tick(3);
    rst_n = 1'b0;
    exp_all_zero(edges, "rst_async");
    #1;
    checks++;
    if (bus.sw_stable !== '0) begin
      errors++;
      $display("FAIL rst_direct_sw: got 'h%0h", bus.sw_stable);
    end
    checks++;
    if (bus.btn_level !== '0) begin
      errors++;
      $display("FAIL rst_direct_level: got 'h%0h", bus.btn_level);
    end
    checks++;
    if (bus.btn_press !== '0) begin
      errors++;
      $display("FAIL rst_direct_press: got 'h%0h", bus.btn_press);
    end
    checks++;
    if (bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_direct_valid: got 'h%0h", bus.evt_valid);
    end
    checks++;
    if (bus.evt_code !== '0) begin
      errors++;
      $display("FAIL rst_direct_code: got 'h%0h", bus.evt_code);
    end
    checks++;
    if (bus.evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_direct_ovf: got 'h%0h", bus.evt_overflow);
    end
    tick(2);
    e = edges;
    rst_n = 1'b1;
    exp_at(e + 5, SigSw, 0, "post_rst_sw_pre");
    exp_at(e + 6, SigSw, 32'h0F0F, "post_rst_sw");
    exp_at(e + 6, SigLevel, 32'h09, "post_rst_level");
    exp_at(e + 6, SigPress, 32'h09, "post_rst_press");
    exp_at(e + 7, SigValid, 1, "post_rst_valid");
    exp_at(e + 7, SigCode, 32'h09, "post_rst_code");
    tick(10);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked: got none expected 'h%0h", sb[0].name, sb[0].val);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
